// File: rtl/cache_mem_arbiter.sv
// Arbitrates one physical-memory port between the icache and dcache, one line
// transaction at a time, with round-robin priority when both sides request.
module cache_mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,

  output logic [1:0]        dbg_state
);

  // Handshake: a requester holds its read/write level until its one-cycle
  // resp pulse; memory sees a held command level until its one-cycle pmem_resp.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  state_t state, next_state;
  grant_t last_grant;

  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              is_write_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;
  logic              i_resp_q;
  logic              d_resp_q;

  logic i_req, d_req;
  logic grant_i, grant_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          // Tie goes to whichever side was not served last.
          if (last_grant == GRANT_I) grant_d = 1'b1;
          else                       grant_i = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_i)      next_state = SERVE_I;
        else if (grant_d) next_state = SERVE_D;
      end
      SERVE_I: if (pmem_resp) next_state = DONE;
      SERVE_D: if (pmem_resp) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= GRANT_I;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_resp_q   <= 1'b0;
      d_resp_q   <= 1'b0;
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      if (grant_i) begin
        addr_q     <= i_pmem_address;
        is_write_q <= 1'b0;
      end
      if (grant_d) begin
        addr_q     <= d_pmem_address;
        wdata_q    <= d_pmem_wdata;
        // A simultaneous read+write from dcache resolves to the write.
        is_write_q <= d_pmem_write;
      end
      if (state == SERVE_I && pmem_resp) begin
        i_rdata_q  <= pmem_rdata;
        i_resp_q   <= 1'b1;
        last_grant <= GRANT_I;
      end
      if (state == SERVE_D && pmem_resp) begin
        // Writebacks return nothing, so the dcache fill data stays intact.
        if (!is_write_q) d_rdata_q <= pmem_rdata;
        d_resp_q   <= 1'b1;
        last_grant <= GRANT_D;
      end
    end
  end

  assign pmem_read    = (state == SERVE_I) || ((state == SERVE_D) && !is_write_q);
  assign pmem_write   = (state == SERVE_D) && is_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_pmem_rdata = i_rdata_q;
  assign i_pmem_resp  = i_resp_q;
  assign d_pmem_rdata = d_rdata_q;
  assign d_pmem_resp  = d_resp_q;

  assign dbg_state = state;

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the single physical-memory port between the instruction cache (fed by the IF stage's always-on fetch) and the data cache. It sequences one cache-line transaction at a time: grant, issue, wait for memory, return data, turnaround. Priority is round-robin on ties. The block sits between the two caches and the cacheline adaptor.

## Interface
- LINE_W, default 256: cache line width in bits.
- ADDR_W, default 32: physical address width.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_pmem_read  in  1  icache line-fill request; held until i_pmem_resp.
- i_pmem_address  in  ADDR_W  icache line address, line-aligned.
- i_pmem_rdata  out  LINE_W  fill data to icache.
- i_pmem_resp  out  1  one-cycle completion pulse to icache.
- d_pmem_read  in  1  dcache line-fill request; held until d_pmem_resp.
- d_pmem_write  in  1  dcache writeback request; held until d_pmem_resp.
- d_pmem_address  in  ADDR_W  dcache line address.
- d_pmem_wdata  in  LINE_W  dcache writeback data.
- d_pmem_rdata  out  LINE_W  fill data to dcache.
- d_pmem_resp  out  1  one-cycle completion pulse to dcache.
- pmem_read  out  1  memory read command, level, held until pmem_resp.
- pmem_write  out  1  memory write command, level, held until pmem_resp.
- pmem_address  out  ADDR_W  latched transaction address.
- pmem_wdata  out  LINE_W  latched write data.
- pmem_rdata  in  LINE_W  memory read data, valid with pmem_resp.
- pmem_resp  in  1  memory completion, one cycle.

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE:
  - Only icache requests: latch i_pmem_address and go to SERVE_I.
  - Only dcache requests: latch address, wdata and the direction (write if d_pmem_write) and go to SERVE_D.
  - Both request: grant the side that was not last_grant.
  - No request: stay in IDLE.
- SERVE_I/SERVE_D:
  - Drive pmem_read or pmem_write from the latched direction. pmem_address and pmem_wdata come from the latch registers, never from live inputs.
  - On pmem_resp: capture pmem_rdata into the granted side's rdata register, pulse that side's resp next cycle, update last_grant, and go to DONE.
- DONE: one turnaround cycle so the served cache can drop its request. Requests are ignored here. Always returns to IDLE.
- Requests arriving during SERVE_x or DONE wait. They are never dropped, since the caches hold them.
- d_pmem_read and d_pmem_write both high is illegal. The write is issued.
- Requester inputs changing after grant have no effect on the in-flight transaction.
- i_pmem_rdata/d_pmem_rdata hold their last captured value until the next capture for that side.
- Reset (async, any state):
  - State goes to IDLE.
  - pmem_read, pmem_write, i_pmem_resp and d_pmem_resp go to 0.
  - pmem_address, pmem_wdata and both rdata registers go to 0.
  - last_grant goes to ICACHE, so the first tie goes to dcache.
  - An in-flight memory transaction is abandoned; a pmem_resp arriving after reset release in IDLE is ignored.

## Timing
- Cycle 0: a request is seen in IDLE.
- Cycle 1: SERVE_x is entered and pmem_read/pmem_write is high.
- Cycle k: memory asserts pmem_resp.
- Cycle k+1:
  - The served side's resp is high for exactly one cycle, with rdata valid in that cycle and after.
  - pmem_read/pmem_write is low and the state is DONE.
- Cycle k+2: IDLE, and a new grant may be made this cycle.
- Minimum request-to-resp latency is 2 cycles, when pmem_resp arrives in cycle 1.
- Back-to-back throughput: one transaction per (memory latency + 3) cycles.
- Fairness: with both sides continuously requesting, grants strictly alternate. Worst-case wait is one full foreign transaction plus turnaround.
- i_pmem_resp and d_pmem_resp are never high in the same cycle.

## Test plan
- Reset then single icache read:
  - Stimulus: i_pmem_read=1 and address 0x0000_0060 at cycle 0; memory returns a pattern with pmem_resp at cycle 4.
  - Required: pmem_read high in cycles 1–4 with pmem_address=0x60; i_pmem_resp pulses at cycle 5 with the pattern; IDLE at cycle 6.
- dcache writeback:
  - Stimulus: d_pmem_write=1 with address 0x8000_1000 and wdata=0xA5 repeated.
  - Required: pmem_write=1, pmem_read=0 and pmem_wdata matching until pmem_resp; a single d_pmem_resp pulse; d_pmem_rdata unchanged.
- Simultaneous requests after reset:
  - Stimulus: i_pmem_read and d_pmem_read both high, held through completion.
  - Required: dcache served first, then icache.
  - Required: a third round with both high again serves dcache, i.e. strict alternation.
- Input change mid-transaction:
  - Stimulus: alter d_pmem_address and d_pmem_wdata after the grant.
  - Required: pmem_address and pmem_wdata keep the latched values.
- Reset mid-transaction:
  - Stimulus: assert rst low in SERVE_I before pmem_resp.
  - Required: all outputs go to 0 immediately; a stray pmem_resp after release produces no resp pulse.
- Illegal dcache read+write:
  - Stimulus: d_pmem_read and d_pmem_write both high.
  - Required: only pmem_write asserted.
